tri_lo_evt_cnt: RTL and testbench
=================================

# tri_lo_evt_cnt

Multi-lane event counter that consumes active-low qualified strobes, such as the outputs of or-and-invert qualifier gates in trilib event logic. It sits on the receiving side of that logic. It registers each active-low lane, detects either low levels or falling edges, and accumulates per-lane saturating counts. Software or debug logic reads each count with a read-and-clear request/valid handshake, and a registered threshold flag is provided per lane.

## Interface
- WIDTH, 4, number of event lanes (1..2**SEL_WIDTH)
- CNT_WIDTH, 8, bits per lane counter (unsigned)
- SEL_WIDTH, 2, width of rd_sel
- clk  in  1  rising-edge clock
- rst  in  1  reset, asynchronous, active-high
- en  in  1  count enable; when 0, counters hold
- edge_mode  in  1  1: count falling edges of evt_b; 0: count every sampled low cycle
- evt_b  in  [0:WIDTH-1]  active-low event inputs, one per lane
- thresh  in  [0:CNT_WIDTH-1]  shared threshold; 0 disables all thresh_hit
- rd_req  in  1  read-and-clear request, single-cycle qualifier
- rd_sel  in  [0:SEL_WIDTH-1]  lane to read
- rd_val  out  1  read data valid
- rd_data  out  [0:CNT_WIDTH-1]  count of the selected lane
- rd_ovf  out  1  sticky saturation flag of the selected lane
- thresh_hit  out  [0:WIDTH-1]  registered per-lane count >= thresh

## Operation
- **Reset values.**
  - rd_val=0, rd_data=0, rd_ovf=0, thresh_hit=0.
  - All counters and ovf flags are 0.
  - Input stage evt_q and history stage evt_p are all ones (inactive).
- **Input stage.** Every cycle, evt_q<=evt_b and evt_p<=evt_q, regardless of en. Edges that occur while en=0 are never counted retroactively.
- **Increment condition per lane i.**
  - inc[i] = en & (edge_mode ? (~evt_q[i] & evt_p[i]) : ~evt_q[i]).
- **Counter update.**
  - If inc[i] and cnt[i] < max, then cnt[i]+1.
  - If inc[i] and cnt[i] == all ones, then cnt[i] holds and ovf[i]<=1. ovf is sticky.
  - Otherwise cnt[i] holds.
- **Read-and-clear.** Applies when rd_req=1 at cycle N and rd_sel=s<WIDTH.
  - rd_data <= cnt[s] (pre-update value at N), rd_ovf <= ovf[s], rd_val <= 1.
  - cnt[s] <= inc[s] ? 1 : 0, so an event coincident with the read is not lost.
  - ovf[s] <= 0.
- **Read with rd_sel >= WIDTH.** rd_val <= 1, rd_data <= 0, rd_ovf <= 0. No lane is modified.
- **Idle read port.** rd_req=0 gives rd_val <= 0. rd_data and rd_ovf hold their last value.
- **Back-to-back reads.** Allowed every cycle, including the same lane twice. The second read returns only the events counted after the first read.
- **Threshold flag.** thresh_hit[i] <= (thresh != 0) & (cnt_next[i] >= thresh).
  - cnt_next is the value written to cnt this cycle, including a read-clear.
- **Reads and enable.** Reads and clears operate when en=0.
- **Mode change.** Changing edge_mode takes effect on the next cycle's inc. No counter is cleared.
- **Arithmetic.** Unsigned, CNT_WIDTH bits, no wrap.

## Timing
- Level mode: evt_b low sampled at edge k, then evt_q low after k. inc is evaluated in cycle k..k+1 and the count is visible after edge k+1. Input-to-count latency is 2 edges.
- Edge mode: the count for a 1→0 transition is visible 2 edges after the first low sample. A held low adds exactly 1.
- Read: rd_req at edge N gives rd_val, rd_data and rd_ovf valid in the cycle after edge N (1-cycle latency). rd_val is high for exactly one cycle per request.
- thresh_hit lags the counter register by 0 cycles (same edge as cnt update). It lags the input by 2 edges.
- Reset asserted mid-operation (including mid-read) clears all state immediately. The first edge after deassertion behaves as after power-on. A pending rd_val is dropped.

## Test plan
- **Level count.** Reset, en=1, edge_mode=0, evt_b[0] low for 5 cycles, then read lane 0 → rd_val one cycle after rd_req, rd_data=5, rd_ovf=0. An immediate re-read returns 0.
- **Edge count.** edge_mode=1, evt_b[1] toggled low/high 3 times plus one low held for 10 cycles, read lane 1 → rd_data=4.
- **Saturation.** CNT_WIDTH=8, level mode, lane 2 low for 300 cycles → rd_data=255, rd_ovf=1. The next read returns 0 with rd_ovf=0.
- **Read coincident with event.** Lane 3 low continuously while rd_req for lane 3 at cycle N → rd_data equals the pre-N count. The next read after M more cycles returns M+1.
- **Threshold.** thresh=3, lane 0 reaches 3 → thresh_hit[0]=1 on that edge. Read-clear drops thresh_hit[0] to 0 on the read edge. thresh=0 keeps all flags 0.
- **Disable and reset.** en=0 with activity yields no count change. rd_sel=3 with WIDTH=3 gives rd_val=1 and rd_data=0. rst asserted mid-count zeroes all outputs asynchronously.

Source files
------------

// File: rtl/tri_lo_evt_cnt.sv
// Multi-lane saturating event counter for active-low qualified strobes.
// Each lane counts low cycles or falling edges, with a read-and-clear port and a per-lane threshold flag.
module tri_lo_evt_cnt #(
  parameter int WIDTH     = 4,
  parameter int CNT_WIDTH = 8,
  parameter int SEL_WIDTH = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 edge_mode,
  input  logic [WIDTH-1:0]     evt_b,
  input  logic [CNT_WIDTH-1:0] thresh,
  input  logic                 rd_req,
  input  logic [SEL_WIDTH-1:0] rd_sel,
  output logic                 rd_val,
  output logic [CNT_WIDTH-1:0] rd_data,
  output logic                 rd_ovf,
  output logic [WIDTH-1:0]     thresh_hit
);

  localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  logic [WIDTH-1:0]     evt_q, evt_p_q;
  logic [CNT_WIDTH-1:0] cnt_q [WIDTH];
  logic [CNT_WIDTH-1:0] cnt_d [WIDTH];
  logic [WIDTH-1:0]     ovf_q, ovf_d;
  logic [WIDTH-1:0]     hit_q, hit_d;
  logic                 rd_val_q, rd_val_d;
  logic [CNT_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                 rd_ovf_q, rd_ovf_d;
  logic [WIDTH-1:0]     inc_s;
  logic                 sel_ok_s;

  assign sel_ok_s = (int'(rd_sel) < WIDTH);

  // Per-lane increment qualifier from the registered input and its history.
  always_comb begin
    inc_s = {WIDTH{1'b0}};
    for (int i = 0; i < WIDTH; i++) begin
      if (edge_mode) begin
        inc_s[i] = en & ~evt_q[i] & evt_p_q[i];
      end else begin
        inc_s[i] = en & ~evt_q[i];
      end
    end
  end

  // Counter, sticky overflow and threshold next-state; a read-clear overrides counting.
  always_comb begin
    ovf_d = ovf_q;
    hit_d = {WIDTH{1'b0}};
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (inc_s[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          ovf_d[i] = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_ONE;
        end
      end else begin
        cnt_d[i] = cnt_q[i];
      end
      // Keep a coincident event so it is not lost across the clear.
      if (rd_req && sel_ok_s && (int'(rd_sel) == i)) begin
        cnt_d[i] = inc_s[i] ? CNT_ONE : CNT_ZERO;
        ovf_d[i] = 1'b0;
      end else begin
        ovf_d[i] = ovf_d[i];
      end
      hit_d[i] = (thresh != CNT_ZERO) && (cnt_d[i] >= thresh);
    end
  end

  // Read port next-state: capture the selected lane's pre-update value.
  always_comb begin
    rd_val_d  = rd_req;
    rd_data_d = rd_data_q;
    rd_ovf_d  = rd_ovf_q;
    if (rd_req) begin
      rd_data_d = CNT_ZERO;
      rd_ovf_d  = 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
        if (sel_ok_s && (int'(rd_sel) == i)) begin
          rd_data_d = cnt_q[i];
          rd_ovf_d  = ovf_q[i];
        end else begin
          rd_data_d = rd_data_d;
        end
      end
    end else begin
      rd_data_d = rd_data_q;
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      evt_q     <= {WIDTH{1'b1}};
      evt_p_q   <= {WIDTH{1'b1}};
      ovf_q     <= {WIDTH{1'b0}};
      hit_q     <= {WIDTH{1'b0}};
      rd_val_q  <= 1'b0;
      rd_data_q <= CNT_ZERO;
      rd_ovf_q  <= 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= CNT_ZERO;
      end
    end else begin
      evt_q     <= evt_b;
      evt_p_q   <= evt_q;
      ovf_q     <= ovf_d;
      hit_q     <= hit_d;
      rd_val_q  <= rd_val_d;
      rd_data_q <= rd_data_d;
      rd_ovf_q  <= rd_ovf_d;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign rd_val     = rd_val_q;
  assign rd_data    = rd_data_q;
  assign rd_ovf     = rd_ovf_q;
  assign thresh_hit = hit_q;

endmodule

// File: tb/tb_tri_lo_evt_cnt.sv
// Self-checking bench for tri_lo_evt_cnt: directed scenarios plus a randomized phase,
// all checked against a cycle-level behavioural model of the counting rules.
module tb_tri_lo_evt_cnt;

  localparam int W  = 3;
  localparam int CW = 8;
  localparam int SW = 2;
  localparam int MAXC = 255;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          edge_mode;
  logic [W-1:0]  evt_b;
  logic [CW-1:0] thresh;
  logic          rd_req;
  logic [SW-1:0] rd_sel;
  logic          rd_val;
  logic [CW-1:0] rd_data;
  logic          rd_ovf;
  logic [W-1:0]  thresh_hit;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int cnt [W];
  bit ovf [W];
  bit s1 [W];
  bit s2 [W];
  bit m_val;
  int m_data;
  bit m_ovf;
  bit m_hit [W];

  tri_lo_evt_cnt #(.WIDTH(W), .CNT_WIDTH(CW), .SEL_WIDTH(SW)) dut (
    .clk(clk), .rst(rst), .en(en), .edge_mode(edge_mode), .evt_b(evt_b),
    .thresh(thresh), .rd_req(rd_req), .rd_sel(rd_sel), .rd_val(rd_val),
    .rd_data(rd_data), .rd_ovf(rd_ovf), .thresh_hit(thresh_hit)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < W; i++) begin
      cnt[i] = 0; ovf[i] = 0; s1[i] = 1; s2[i] = 1; m_hit[i] = 0;
    end
    m_val = 0; m_data = 0; m_ovf = 0;
  endtask

  // Apply one clock edge to the model using the inputs currently driven.
  task automatic model_edge();
    bit inc [W];
    bit low;
    for (int i = 0; i < W; i++) begin
      low = !s1[i];
      inc[i] = en && (edge_mode ? (low && s2[i]) : low);
    end
    if (rd_req) begin
      m_val = 1;
      if (int'(rd_sel) < W) begin
        m_data = cnt[rd_sel]; m_ovf = ovf[rd_sel];
      end else begin
        m_data = 0; m_ovf = 0;
      end
    end else begin
      m_val = 0;
    end
    for (int i = 0; i < W; i++) begin
      if (inc[i]) begin
        if (cnt[i] == MAXC) ovf[i] = 1;
        else cnt[i] = cnt[i] + 1;
      end
      if (rd_req && int'(rd_sel) == i) begin
        cnt[i] = inc[i] ? 1 : 0;
        ovf[i] = 0;
      end
      m_hit[i] = (thresh != 0) && (cnt[i] >= int'(thresh));
      s2[i] = s1[i];
      s1[i] = evt_b[i];
    end
  endtask

  task automatic compare_all();
    chk("rd_val", rd_val, m_val);
    chk("rd_data", rd_data, m_data);
    chk("rd_ovf", rd_ovf, m_ovf);
    for (int i = 0; i < W; i++) chk($sformatf("thresh_hit%0d", i), thresh_hit[i], m_hit[i]);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; edge_mode = 1'b0; evt_b = 3'b111;
    thresh = 8'd0; rd_req = 1'b0; rd_sel = 2'd0;
    model_reset();
    #13;
    chk("reset_rd_val", rd_val, 1'b0);
    chk("reset_rd_data", rd_data, 8'd0);
    chk("reset_hit", thresh_hit, 3'b000);
    @(negedge clk); rst = 1'b0;

    // Level count on lane 0
    en = 1'b1;
    evt_b[0] = 1'b0;
    repeat (5) step();
    evt_b[0] = 1'b1;
    repeat (2) step();
    rd_req = 1'b1; rd_sel = 2'd0;
    step();
    chk("level_val", rd_val, 1'b1);
    chk("level_cnt5", rd_data, 8'd5);
    chk("level_ovf", rd_ovf, 1'b0);
    step();
    chk("reread_zero", rd_data, 8'd0);
    rd_req = 1'b0;
    step();
    chk("val_one_cycle", rd_val, 1'b0);

    // Edge count on lane 1
    edge_mode = 1'b1;
    repeat (3) begin
      evt_b[1] = 1'b0; step();
      evt_b[1] = 1'b1; step();
    end
    evt_b[1] = 1'b0;
    repeat (10) step();
    evt_b[1] = 1'b1;
    repeat (2) step();
    rd_req = 1'b1; rd_sel = 2'd1;
    step();
    chk("edge_cnt4", rd_data, 8'd4);
    rd_req = 1'b0;

    // Saturation on lane 2
    edge_mode = 1'b0;
    evt_b[2] = 1'b0;
    repeat (300) step();
    evt_b[2] = 1'b1;
    repeat (2) step();
    rd_req = 1'b1; rd_sel = 2'd2;
    step();
    chk("sat_data", rd_data, 8'd255);
    chk("sat_ovf", rd_ovf, 1'b1);
    step();
    chk("sat_clear_data", rd_data, 8'd0);
    chk("sat_clear_ovf", rd_ovf, 1'b0);
    rd_req = 1'b0;

    // Read coincident with an active event on lane 2
    evt_b[2] = 1'b0;
    repeat (5) step();
    rd_req = 1'b1; rd_sel = 2'd2;
    step();
    chk("coinc_pre", rd_data, 8'd4);
    rd_req = 1'b0;
    repeat (3) step();
    rd_req = 1'b1;
    step();
    chk("coinc_m_plus_1", rd_data, 8'd4);
    rd_req = 1'b0;
    evt_b[2] = 1'b1;
    repeat (2) step();
    rd_req = 1'b1;
    step();
    rd_req = 1'b0;

    // Threshold on lane 0
    thresh = 8'd3;
    evt_b[0] = 1'b0;
    repeat (3) step();
    chk("thr_below", thresh_hit[0], 1'b0);
    evt_b[0] = 1'b1;
    step();
    chk("thr_hit", thresh_hit[0], 1'b1);
    rd_req = 1'b1; rd_sel = 2'd0;
    step();
    chk("thr_clear", thresh_hit[0], 1'b0);
    rd_req = 1'b0;
    thresh = 8'd0;
    evt_b = 3'b000;
    repeat (6) step();
    chk("thr_zero_off", thresh_hit, 3'b000);

    // Disable with activity, then out-of-range read
    en = 1'b0;
    for (int k = 0; k < 12; k++) begin
      evt_b = W'($urandom);
      step();
    end
    rd_req = 1'b1; rd_sel = 2'd3;
    step();
    chk("badsel_val", rd_val, 1'b1);
    chk("badsel_data", rd_data, 8'd0);
    rd_req = 1'b0;
    en = 1'b1;

    // Randomized phase
    for (int k = 0; k < 500; k++) begin
      if ($urandom_range(0, 15) == 0) en = ~en;
      if ($urandom_range(0, 31) == 0) edge_mode = ~edge_mode;
      if ($urandom_range(0, 63) == 0) thresh = CW'($urandom_range(0, 12));
      evt_b  = W'($urandom);
      rd_req = ($urandom_range(0, 3) == 0);
      rd_sel = SW'($urandom_range(0, 3));
      step();
    end

    // Asynchronous reset mid-read
    en = 1'b1; edge_mode = 1'b0; evt_b = 3'b000; thresh = 8'd1;
    repeat (4) step();
    rd_req = 1'b1; rd_sel = 2'd1;
    step();
    chk("pre_rst_val", rd_val, 1'b1);
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk("rst_async_val", rd_val, 1'b0);
    chk("rst_async_data", rd_data, 8'd0);
    chk("rst_async_hit", thresh_hit, 3'b000);
    @(negedge clk); rst = 1'b0;
    rd_req = 1'b0; evt_b = 3'b111;
    repeat (3) step();
    rd_req = 1'b1; rd_sel = 2'd1;
    step();
    chk("post_rst_cnt", rd_data, 8'd0);
    rd_req = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
